sqrt_pipelined_exact: RTL and testbench

//  Fully pipelined, exact unsigned integer square root with an optional fractional result.

---
 rtl/sqrt_pipelined_exact_if.sv | 29 ++
 rtl/sqrt_pipelined_exact.sv | 114 +++++++++++
 tb/tb_sqrt_pipelined_exact.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sqrt_pipelined_exact_if.sv
// Valid/ready stream bundle for the pipelined square root: radicand+tag in, root+remainder+tag out.
// The slave modport is the square-root block; the master modport is whoever feeds and drains it.
interface sqrt_pipelined_exact_if #(
  parameter int BITS = 32,
  parameter int FRAC = 0,
  parameter int TAGW = 8
);
  localparam int RW = BITS / 2 + FRAC;

  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_x;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [RW-1:0]   out_sqrt;
  logic [RW:0]     out_rem;
  logic [TAGW-1:0] out_tag;

  modport master (
    output in_valid, in_x, in_tag, out_ready,
    input  in_ready, out_valid, out_sqrt, out_rem, out_tag
  );

  modport slave (
    input  in_valid, in_x, in_tag, out_ready,
    output in_ready, out_valid, out_sqrt, out_rem, out_tag
  );
endinterface

// File: rtl/sqrt_pipelined_exact.sv
// Fully pipelined restoring square root: one root bit per iteration, REG_EVERY iterations per
// register stage, exact floor(sqrt(x*4^FRAC)) plus remainder, tag carried in lockstep.
module sqrt_pipelined_exact #(
  parameter int BITS      = 32,
  parameter int FRAC      = 0,
  parameter int REG_EVERY = 1,
  parameter int TAGW      = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  sqrt_pipelined_exact_if.slave bus
);
  localparam int RW   = BITS / 2 + FRAC;
  localparam int RADW = 2 * RW;
  localparam int LAT  = (RW + REG_EVERY - 1) / REG_EVERY;
  localparam int STW  = RW + (RW + 2) + RADW;

  // Runs the iterations belonging to one stage; iterations past RW (short last stage) pass through.
  function automatic logic [STW-1:0] sqrtStage(
    input logic [RW-1:0]   qIn,
    input logic [RW+1:0]   rIn,
    input logic [RADW-1:0] radIn,
    input int              first
  );
    logic [RW-1:0]   q;
    logic [RW+1:0]   r;
    logic [RW+1:0]   rp;
    logic [RW+1:0]   t;
    logic [RADW-1:0] rad;
    q   = qIn;
    r   = rIn;
    rad = radIn;
    rp  = '0;
    t   = '0;
    for (int k = 0; k < REG_EVERY; k++) begin
      if (first + k < RW) begin
        rp  = {r[RW-1:0], rad[RADW-1 -: 2]};
        t   = {q, 2'b01};
        rad = rad << 2;
        if (rp >= t) begin
          r = rp - t;
          q = {q[RW-2:0], 1'b1};
        end else begin
          r = rp;
          q = {q[RW-2:0], 1'b0};
        end
      end
    end
    return {q, r, rad};
  endfunction

  logic [LAT-1:0]  r_valid;
  logic [TAGW-1:0] r_tag [LAT];
  logic [RW-1:0]   r_q   [LAT];
  logic [RW+1:0]   r_r   [LAT];
  logic [RADW-1:0] r_rad [LAT];

  logic [LAT-1:0]  w_srcValid;
  logic [TAGW-1:0] w_srcTag [LAT];
  logic [RW-1:0]   w_srcQ   [LAT];
  logic [RW+1:0]   w_srcR   [LAT];
  logic [RADW-1:0] w_srcRad [LAT];
  logic [RW-1:0]   w_nxQ    [LAT];
  logic [RW+1:0]   w_nxR    [LAT];
  logic [RADW-1:0] w_nxRad  [LAT];

  logic w_stall;
  logic w_unused;

  assign w_stall     = r_valid[LAT-1] & ~bus.out_ready;
  assign bus.in_ready = ~w_stall;

  always_comb begin
    w_srcValid[0] = bus.in_valid;
    w_srcTag[0]   = bus.in_tag;
    w_srcQ[0]     = '0;
    w_srcR[0]     = '0;
    w_srcRad[0]   = RADW'(bus.in_x) << (2 * FRAC);
    for (int s = 1; s < LAT; s++) begin
      w_srcValid[s] = r_valid[s-1];
      w_srcTag[s]   = r_tag[s-1];
      w_srcQ[s]     = r_q[s-1];
      w_srcR[s]     = r_r[s-1];
      w_srcRad[s]   = r_rad[s-1];
    end
    for (int s = 0; s < LAT; s++) begin
      {w_nxQ[s], w_nxR[s], w_nxRad[s]} =
        sqrtStage(w_srcQ[s], w_srcR[s], w_srcRad[s], s * REG_EVERY);
    end
  end

  // Every stage, empty or not, shifts together unless the output is blocked.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (!w_stall) begin
      r_valid <= w_srcValid;
      for (int s = 0; s < LAT; s++) begin
        r_tag[s] <= w_srcTag[s];
        r_q[s]   <= w_nxQ[s];
        r_r[s]   <= w_nxR[s];
        r_rad[s] <= w_nxRad[s];
      end
    end
  end

  assign bus.out_valid = r_valid[LAT-1];
  assign bus.out_sqrt  = r_valid[LAT-1] ? r_q[LAT-1]       : '0;
  assign bus.out_rem   = r_valid[LAT-1] ? r_r[LAT-1][RW:0] : '0;
  assign bus.out_tag   = r_valid[LAT-1] ? r_tag[LAT-1]     : '0;

  // The remainder's spare top bit and the fully consumed radicand never reach the output.
  assign w_unused = ^{r_r[LAT-1][RW+1], r_rad[LAT-1]};
endmodule

// File: tb/tb_sqrt_pipelined_exact.sv
// Directed and randomised checks of sqrt_pipelined_exact in two configurations:
// A = 32 bits, integer root, one iteration per stage; C = 32 bits, 8 fraction bits, four per stage.
module tb_sqrt_pipelined_exact;
  localparam int LAT_A = 16;
  localparam int LAT_C = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sqrt_pipelined_exact_if #(.BITS(32), .FRAC(0), .TAGW(8)) busA ();
  sqrt_pipelined_exact_if #(.BITS(32), .FRAC(8), .TAGW(8)) busC ();

  sqrt_pipelined_exact #(.BITS(32), .FRAC(0), .REG_EVERY(1), .TAGW(8)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(busA)
  );
  sqrt_pipelined_exact #(.BITS(32), .FRAC(8), .REG_EVERY(4), .TAGW(8)) dutC (
    .clk(clk), .rst_n(rst_n), .bus(busC)
  );

  int total = 0;
  int bad = 0;
  int received = 0;
  logic [31:0] xQ[$];
  logic [7:0]  tagQ[$];
  logic [7:0]  nextTag = 8'h00;

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One sample through A with an idle pipeline and out_ready held high.
  task automatic applyStimulusA(input string name, input logic [31:0] x, input logic [7:0] tag,
                                input logic [15:0] expSqrt, input logic [16:0] expRem);
    int cyc;
    busA.in_valid  = 1'b1;
    busA.in_x      = x;
    busA.in_tag    = tag;
    busA.out_ready = 1'b1;
    step();
    busA.in_valid = 1'b0;
    cyc = 1;
    while (!busA.out_valid && cyc < 100) begin
      step();
      cyc++;
    end
    checkOutput({name, "_latency"}, 64'(cyc), 64'(LAT_A));
    checkOutput({name, "_sqrt"}, 64'(busA.out_sqrt), 64'(expSqrt));
    checkOutput({name, "_rem"}, 64'(busA.out_rem), 64'(expRem));
    checkOutput({name, "_tag"}, 64'(busA.out_tag), 64'(tag));
    step();
    checkOutput({name, "_idle_after"}, 64'({busA.out_valid, busA.out_sqrt, busA.out_rem}), 64'd0);
  endtask

  task automatic applyStimulusC(input string name, input logic [31:0] x, input logic [7:0] tag,
                                input logic [23:0] expSqrt, input logic [24:0] expRem);
    int cyc;
    busC.in_valid  = 1'b1;
    busC.in_x      = x;
    busC.in_tag    = tag;
    busC.out_ready = 1'b1;
    step();
    busC.in_valid = 1'b0;
    cyc = 1;
    while (!busC.out_valid && cyc < 100) begin
      step();
      cyc++;
    end
    checkOutput({name, "_latency"}, 64'(cyc), 64'(LAT_C));
    checkOutput({name, "_sqrt"}, 64'(busC.out_sqrt), 64'(expSqrt));
    checkOutput({name, "_rem"}, 64'(busC.out_rem), 64'(expRem));
    checkOutput({name, "_tag"}, 64'(busC.out_tag), 64'(tag));
  endtask

  // One clock of streaming traffic on A, checked against the sent-sample scoreboard.
  task automatic runCycle(input bit vld, input bit ordy);
    logic [31:0] x;
    logic [31:0] x0;
    logic [7:0]  t0;
    logic [63:0] sq;
    logic [63:0] rem;
    logic [15:0] hSqrt;
    logic [16:0] hRem;
    logic [7:0]  hTag;
    bit expReady, sent, stalled, remOk;
    x = $urandom;
    busA.in_valid  = vld;
    busA.in_x      = x;
    busA.in_tag    = nextTag;
    busA.out_ready = ordy;
    #1;
    expReady = !(busA.out_valid && !ordy);
    checkOutput("in_ready", 64'(busA.in_ready), 64'(expReady));
    sent    = vld && busA.in_ready;
    stalled = busA.out_valid && !ordy;
    if (busA.out_valid && ordy) begin
      if (xQ.size() == 0) begin
        checkOutput("spurious_result", 64'(xQ.size()), 64'd1);
      end else begin
        x0  = xQ.pop_front();
        t0  = tagQ.pop_front();
        sq  = 64'(busA.out_sqrt);
        rem = 64'(busA.out_rem);
        remOk = (rem <= 2 * sq);
        checkOutput("sqrt2_plus_rem", sq * sq + rem, 64'(x0));
        checkOutput("rem_bound", 64'(remOk), 64'd1);
        checkOutput("tag_order", 64'(busA.out_tag), 64'(t0));
        received++;
      end
    end
    hSqrt = busA.out_sqrt;
    hRem  = busA.out_rem;
    hTag  = busA.out_tag;
    step();
    if (sent) begin
      xQ.push_back(x);
      tagQ.push_back(nextTag);
      nextTag++;
    end
    if (stalled) begin
      checkOutput("stall_hold", 64'({busA.out_valid, busA.out_sqrt, busA.out_rem, busA.out_tag}),
                  64'({1'b1, hSqrt, hRem, hTag}));
    end
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    busA.in_valid = 1'b0; busA.in_x = '0; busA.in_tag = '0; busA.out_ready = 1'b1;
    busC.in_valid = 1'b0; busC.in_x = '0; busC.in_tag = '0; busC.out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;

    checkOutput("reset_out_valid", 64'(busA.out_valid), 64'd0);
    checkOutput("reset_outputs", 64'({busA.out_sqrt, busA.out_rem, busA.out_tag}), 64'd0);
    checkOutput("reset_in_ready", 64'(busA.in_ready), 64'd1);
    checkOutput("reset_c_out_valid", 64'(busC.out_valid), 64'd0);

    applyStimulusA("x16", 32'd16, 8'h01, 16'd4, 17'd0);
    applyStimulusA("x0", 32'd0, 8'h02, 16'd0, 17'd0);
    applyStimulusA("xmax", 32'hFFFF_FFFF, 8'h03, 16'hFFFF, 17'h1FFFE);
    applyStimulusA("xsquare", 32'hFFFE_0001, 8'h04, 16'hFFFF, 17'd0);

    applyStimulusC("frac_x2", 32'd2, 8'h11, 24'd362, 25'd28);
    applyStimulusC("frac_x16", 32'd16, 8'h12, 24'd1024, 25'd0);
    applyStimulusC("frac_xmax", 32'hFFFF_FFFF, 8'h13, 24'hFFFFFF, 25'h1FEFFFF);

    received = 0;
    nextTag  = 8'h00;
    for (int i = 0; i < 1000 + LAT_A; i++) runCycle(i < 1000, 1'b1);
    checkOutput("stream_count", 64'(received), 64'd1000);
    checkOutput("stream_queue_empty", 64'(xQ.size()), 64'd0);

    for (int i = 0; i < 400; i++) runCycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    guard = 0;
    while (xQ.size() != 0 && guard < 200) begin
      runCycle(1'b0, 1'b1);
      guard++;
    end
    checkOutput("random_drain_empty", 64'(xQ.size()), 64'd0);

    for (int i = 0; i < 10; i++) runCycle(1'b1, 1'b1);
    busA.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    xQ.delete();
    tagQ.delete();
    for (int i = 0; i < LAT_A; i++) begin
      checkOutput("post_reset_quiet", 64'(busA.out_valid), 64'd0);
      step();
    end
    applyStimulusA("post_reset", 32'd1000000, 8'h5A, 16'd1000, 17'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
